// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode encoding, flag bundle, skid states
// and the flag derivation used on the input side of the stage.
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_NOT = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
      logic illegal;
   } alu_flags_t;

   typedef enum logic [1:0] {
      SKID_EMPTY,
      SKID_ONE,
      SKID_TWO
   } skid_state_e;

   // ADD/SUB overflow: the result sign disagrees with what the operand signs allow.
   function automatic alu_flags_t calc_flags(
      input logic [OP_W-1:0] op,
      input logic            a_msb,
      input logic            b_msb,
      input logic            r_msb,
      input logic            r_zero,
      input logic            add_carry,
      input logic            sub_borrow
   );
      alu_flags_t f;
      f = '0;
      if (op > OP_XOR) begin
         f.zero    = 1'b1;
         f.illegal = 1'b1;
      end else begin
         f.zero = r_zero;
         f.neg  = r_msb;
         if (op == OP_ADD) begin
            f.carry = add_carry;
            f.ovf   = (a_msb == b_msb) && (r_msb != a_msb);
         end else if (op == OP_SUB) begin
            f.carry = sub_borrow;
            f.ovf   = (a_msb != b_msb) && (r_msb != a_msb);
         end
      end
      return f;
   endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer, 1-cycle latency; in_rdy_o is registered and drops only when
// both entries are held, so full throughput survives a stalled consumer.
module alu_skid_buf
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_vld_i,
   output logic         in_rdy_o,
   input  logic [W-1:0] in_dat_i,
   output logic         out_vld_o,
   input  logic         out_rdy_i,
   output logic [W-1:0] out_dat_o
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] m_q, m_d;
   logic [W-1:0] s_q, s_d;
   logic         in_rdy_q, in_rdy_d;
   logic         accept, emit;

   assign accept = in_vld_i && in_rdy_q;
   assign emit   = (state_q != SKID_EMPTY) && out_rdy_i;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
         SKID_EMPTY: begin
            if (accept) begin
               m_d     = in_dat_i;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (accept && emit) begin
               m_d = in_dat_i;
            end else if (accept) begin
               s_d     = in_dat_i;
               state_d = SKID_TWO;
            end else if (emit) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            if (emit) begin
               m_d     = s_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      in_rdy_d = (state_d != SKID_TWO);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= SKID_EMPTY;
         m_q      <= '0;
         s_q      <= '0;
         in_rdy_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         s_q      <= s_d;
         in_rdy_q <= in_rdy_d;
      end
   end

   assign in_rdy_o  = in_rdy_q;
   assign out_vld_o = (state_q != SKID_EMPTY);
   assign out_dat_o = m_q;

endmodule

// File: rtl/alu_result_stage.sv
// Selects the requested ALU result, derives flags and registers both (1 cycle) behind a
// 2-entry skid buffer. Optional sticky overflow: ALU_RESULT_STICKY_OVF_EN.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = OP_W
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] a_plus_b,
   input  logic [DATA_WIDTH-1:0] a_minus_b,
   input  logic [DATA_WIDTH-1:0] not_a,
   input  logic [DATA_WIDTH-1:0] a_and_b,
   input  logic [DATA_WIDTH-1:0] a_or_b,
   input  logic [DATA_WIDTH-1:0] a_xor_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_zero,
   output logic                  out_neg,
   output logic                  out_carry,
   output logic                  out_ovf,
   output logic                  out_illegal
`ifdef ALU_RESULT_STICKY_OVF_EN
   ,
   input  logic                  sticky_clr,
   output logic                  sticky_ovf
`endif
);

   localparam int PW = DATA_WIDTH + $bits(alu_flags_t);

   logic [OP_W-1:0]       op_w;
   logic [DATA_WIDTH-1:0] sel_res;
   alu_flags_t            in_flags;
   alu_flags_t            out_flags;
   logic [PW-1:0]         out_dat;

   assign op_w = OP_W'(op);

   always_comb begin
      sel_res = '0;
      case (op_w)
         OP_ADD:  sel_res = a_plus_b;
         OP_SUB:  sel_res = a_minus_b;
         OP_NOT:  sel_res = not_a;
         OP_AND:  sel_res = a_and_b;
         OP_OR:   sel_res = a_or_b;
         OP_XOR:  sel_res = a_xor_b;
         default: sel_res = '0;
      endcase
   end

   assign in_flags = calc_flags(op_w, a[DATA_WIDTH-1], b[DATA_WIDTH-1],
                                sel_res[DATA_WIDTH-1], (sel_res == '0),
                                (a_plus_b < a), (a < b));

   alu_skid_buf #(.W(PW)) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .in_vld_i  (in_valid),
      .in_rdy_o  (in_ready),
      .in_dat_i  ({sel_res, in_flags}),
      .out_vld_o (out_valid),
      .out_rdy_i (out_ready),
      .out_dat_o (out_dat)
   );

   assign {out_result, out_flags} = out_dat;
   assign out_zero    = out_flags.zero;
   assign out_neg     = out_flags.neg;
   assign out_carry   = out_flags.carry;
   assign out_ovf     = out_flags.ovf;
   assign out_illegal = out_flags.illegal;

`ifdef ALU_RESULT_STICKY_OVF_EN
   logic sticky_q, sticky_d;

   // A set on an emitted overflow beat overrides a same-cycle clear.
   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr) sticky_d = 1'b0;
      if (out_valid && out_ready && out_ovf) sticky_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) sticky_q <= 1'b0;
      else         sticky_q <= sticky_d;
   end

   assign sticky_ovf = sticky_q;
`else
   // Default build carries no sticky overflow state.
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed corner steps plus randomized traffic, scored against
// a queue-based reference computed with plain wide/signed arithmetic.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready;
   logic [2:0]  op;
   logic [31:0] a, b, a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_zero, out_neg, out_carry, out_ovf, out_illegal;

   typedef struct {
      logic [31:0] r;
      logic [4:0]  f;   // zero, neg, carry, ovf, illegal
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_result_stage dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .a_plus_b(a_plus_b), .a_minus_b(a_minus_b), .not_a(not_a),
      .a_and_b(a_and_b), .a_or_b(a_or_b), .a_xor_b(a_xor_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
      .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf), .out_illegal(out_illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_beat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      int     sx, sy;
      longint s;
      logic [32:0] wide;
      logic   c, v, il;
      sx = x; sy = y;
      c = 1'b0; v = 1'b0; il = 1'b0;
      case (o)
         3'd0: begin
            wide = {1'b0, x} + {1'b0, y};
            e.r  = wide[31:0];
            c    = wide[32];
            s    = longint'(sx) + longint'(sy);
            v    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            e.r = x - y;
            c   = (x < y);
            s   = longint'(sx) - longint'(sy);
            v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: e.r = ~x;
         3'd3: e.r = x & y;
         3'd4: e.r = x | y;
         3'd5: e.r = x ^ y;
         default: begin e.r = 32'd0; il = 1'b1; end
      endcase
      e.f = {(e.r == 32'd0), e.r[31], c, v, il};
      return e;
   endfunction

   task automatic set_beat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y;
      a_plus_b = x + y; a_minus_b = x - y; not_a = ~x;
      a_and_b = x & y; a_or_b = x | y; a_xor_b = x ^ y;
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 4))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   // One clock: score what is presented now, then check occupancy-derived handshake after the edge.
   task automatic tick();
      bit acc, emt;
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      if (out_valid === 1'b1 && q.size() > 0) begin
         check("result", out_result, q[0].r);
         check("flags", {27'd0, out_zero, out_neg, out_carry, out_ovf, out_illegal}, {27'd0, q[0].f});
      end
      if (emt && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(ref_beat(op, a, b));
      @(posedge clk); #1;
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < 2);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_result"}, out_result, 0);
      check({tag, "_flags"}, {27'd0, out_zero, out_neg, out_carry, out_ovf, out_illegal}, 0);
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      set_beat(3'd0, 32'h1234_5678, 32'h1111_1111);
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      resetn = 1'b1; in_valid = 1'b0;
      tick();

      // ADD wrap
      set_beat(3'd0, 32'hFFFF_FFFF, 32'd1); in_valid = 1'b1;
      tick();
      check("add_wrap_result", out_result, 32'd0);
      check("add_wrap_zcno", {28'd0, out_zero, out_carry, out_ovf, out_neg}, 32'b1100);
      in_valid = 1'b0; tick();

      // SUB overflow and borrow
      set_beat(3'd1, 32'h8000_0000, 32'd1); in_valid = 1'b1;
      tick();
      check("sub_ovf_result", out_result, 32'h7FFF_FFFF);
      check("sub_ovf_ocn", {29'd0, out_ovf, out_carry, out_neg}, 32'b100);
      set_beat(3'd1, 32'd3, 32'd5);
      tick();
      check("sub_borrow_result", out_result, 32'hFFFF_FFFE);
      check("sub_borrow_cn", {30'd0, out_carry, out_neg}, 32'b11);
      in_valid = 1'b0; tick();

      // Backpressure: third beat must wait upstream
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(3'd5, 32'hF0, 32'h0F);                tick();
      set_beat(3'd3, 32'hFF00_FF00, 32'h0FF0_0FF0);  tick();
      check("bp_in_ready_low", in_ready, 0);
      set_beat(3'd4, 32'h1234_0000, 32'h0000_5678);  tick();
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_result", out_result, 32'hFF);
      out_ready = 1'b1; tick();
      check("bp_second", out_result, 32'h0F00_0F00);
      tick();
      check("bp_third", out_result, 32'h1234_5678);
      in_valid = 1'b0; tick();

      // Illegal opcode
      set_beat(3'd7, $urandom, $urandom); in_valid = 1'b1;
      tick();
      check("illegal_result", out_result, 32'd0);
      check("illegal_iz", {30'd0, out_illegal, out_zero}, 32'b11);
      in_valid = 1'b0; tick();

      // Back-to-back streaming
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_beat(3'($urandom_range(0, 5)), rand_data(), rand_data());
         tick();
         check("stream_valid", out_valid, 1);
      end
      in_valid = 1'b0; tick();

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         set_beat(3'($urandom_range(0, 7)), rand_data(), rand_data());
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();

      // Reset while both entries are held
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(3'd0, 32'd10, 32'd20); tick();
      set_beat(3'd4, 32'd1, 32'd2);   tick();
      check("pre_reset_full", in_ready, 0);
      resetn = 1'b0;
      @(posedge clk); #1;
      q.delete();
      check_reset_state("midreset");
      resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
